// File: rtl/led_pos_display_if.sv
// Timer position bus shared with the LED driver, plus the display outputs.
// master drives the one-hot position; slave is the display consumer.
interface led_pos_display_if #(
   parameter int WIDTH = 21
);
   logic [WIDTH-1:0] pos_in;
   logic [7:0]       an;
   logic [7:0]       seg;
   logic [4:0]       idx_o;
   logic [6:0]       lap_o;
   logic             err_o;

   modport master (
      output pos_in,
      input  an, seg, idx_o, lap_o, err_o
   );

   modport slave (
      input  pos_in,
      output an, seg, idx_o, lap_o, err_o
   );
endinterface

// File: rtl/led_pos_display.sv
// One-hot position encoder, lap counter and 8-digit multiplexed
// seven-segment scanner for the LED chase timer.
module led_pos_display #(
   parameter int WIDTH    = 21,
   parameter int SCAN_DIV = 100_000,
   parameter int LAP_MOD  = 100
) (
   input logic              clk,
   input logic              rst,
   led_pos_display_if.slave bus
);
   localparam int CW = $clog2(SCAN_DIV);

   logic [WIDTH-1:0] pos_q;
   logic [4:0]       idx_q;
   logic [4:0]       enc;
   logic [6:0]       lap_q;
   logic             err_q;
   logic             prev_valid;
   logic             valid;
   logic             lap_step;
   logic [CW-1:0]    scan_cnt;
   logic [2:0]       ptr;
   logic [7:0]       an_q;
   logic [7:0]       seg_q;
   logic [7:0]       seg_nx;
   logic [7:0]       i_bcd;
   logic [7:0]       l_bcd;

   function automatic logic [7:0] seg7(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = 8'hC0;
         4'd1:    s = 8'hF9;
         4'd2:    s = 8'hA4;
         4'd3:    s = 8'hB0;
         4'd4:    s = 8'h99;
         4'd5:    s = 8'h92;
         4'd6:    s = 8'h82;
         4'd7:    s = 8'hF8;
         4'd8:    s = 8'h80;
         4'd9:    s = 8'h90;
         default: s = 8'hFF;
      endcase
      return s;
   endfunction

   // Values never exceed 99: compare against each multiple of ten,
   // then subtract the tens once.
   function automatic logic [7:0] bcd(input logic [6:0] v);
      logic [3:0] t;
      t = 4'd0;
      for (int k = 1; k < 10; k++)
         if (v >= 7'(10 * k)) t = 4'(k);
      return {t, 4'(v - 7'd10 * {3'd0, t})};
   endfunction

   always_comb begin
      enc   = 5'd0;
      valid = ($countones(pos_q) == 1);
      for (int i = 0; i < WIDTH; i++)
         if (pos_q[i]) enc = 5'(i);
      lap_step = valid && prev_valid && (enc != idx_q)
              && (idx_q == 5'(WIDTH - 1)) && (enc == 5'd0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pos_q      <= '0;
         idx_q      <= '0;
         err_q      <= 1'b0;
         prev_valid <= 1'b0;
         lap_q      <= '0;
      end else begin
         pos_q <= bus.pos_in;
         if (valid) begin
            idx_q      <= enc;
            err_q      <= 1'b0;
            prev_valid <= 1'b1;
         end else begin
            err_q      <= 1'b1;
            prev_valid <= 1'b0;
         end
         if (lap_step)
            lap_q <= (lap_q == 7'(LAP_MOD - 1)) ? 7'd0 : lap_q + 7'd1;
      end
   end

   always_comb begin
      seg_nx = 8'hFF;
      i_bcd  = bcd({2'b00, idx_q});
      l_bcd  = bcd(lap_q);
      unique case (ptr)
         3'd0: seg_nx = err_q ? 8'hBF : seg7(i_bcd[3:0]);
         3'd1: seg_nx = err_q ? 8'hBF :
                        (i_bcd[7:4] == 4'd0) ? 8'hFF : seg7(i_bcd[7:4]);
         3'd4: seg_nx = seg7(l_bcd[3:0]);
         3'd5: seg_nx = (l_bcd[7:4] == 4'd0) ? 8'hFF : seg7(l_bcd[7:4]);
         default: seg_nx = 8'hFF;
      endcase
   end

   // ptr names the digit loaded on the next advance, so an and seg
   // always switch together on one edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scan_cnt <= '0;
         ptr      <= 3'd0;
         an_q     <= 8'hFF;
         seg_q    <= 8'hFF;
      end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
         scan_cnt <= '0;
         ptr      <= ptr + 3'd1;
         an_q     <= ~(8'h01 << ptr);
         seg_q    <= seg_nx;
      end else begin
         scan_cnt <= scan_cnt + CW'(1);
      end
   end

   assign bus.an    = an_q;
   assign bus.seg   = seg_q;
   assign bus.idx_o = idx_q;
   assign bus.lap_o = lap_q;
   assign bus.err_o = err_q;
endmodule

// File: tb/tb_led_pos_display.sv
// Scoreboard bench for led_pos_display: stimulus queues expectations,
// a negedge monitor pops and compares them.
module tb_led_pos_display;
   typedef struct {
      string      nm;
      int         kind;
      logic [7:0] val;
      int         due;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   exp_t sbq[$];
   logic [7:0] prev_an = 8'hFF;

   logic [7:0] an_tbl [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7,
                              8'hEF, 8'hDF, 8'hBF, 8'h7F};
   logic [7:0] seg_tbl [8] = '{8'hC0, 8'hFF, 8'hFF, 8'hFF,
                               8'hC0, 8'hFF, 8'hFF, 8'hFF};

   led_pos_display_if #(.WIDTH(21)) bus ();

   led_pos_display #(
      .WIDTH(21),
      .SCAN_DIV(4),
      .LAP_MOD(100)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %02h want %02h at cycle %0d",
                    nm, act, exp, cyc);
   endtask

   // kind: 0 an, 1 seg, 2 idx, 3 lap, 4 err, 10+p digit p on refresh
   always @(negedge clk) begin
      for (int i = sbq.size() - 1; i >= 0; i--) begin
         exp_t e;
         logic [7:0] act;
         int p;
         e = sbq[i];
         case (e.kind)
            0:       act = bus.an;
            1:       act = bus.seg;
            2:       act = {3'b000, bus.idx_o};
            3:       act = {1'b0, bus.lap_o};
            4:       act = {7'd0, bus.err_o};
            default: act = bus.seg;
         endcase
         if (e.kind < 10) begin
            if (e.due == cyc) begin
               chk(e.nm, act, e.val);
               sbq.delete(i);
            end else if (e.due < cyc) begin
               chk({e.nm, "_expired"}, 8'hXX, e.val);
               sbq.delete(i);
            end
         end else begin
            p = e.kind - 10;
            if (cyc > e.due && bus.an == ~(8'h01 << p) && prev_an != bus.an) begin
               chk(e.nm, act, e.val);
               sbq.delete(i);
            end else if (cyc > e.due + 40) begin
               chk({e.nm, "_timeout"}, bus.an, ~(8'h01 << p));
               sbq.delete(i);
            end
         end
      end
      prev_an = bus.an;
   end

   task automatic tick(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(string nm, int kind, logic [7:0] v, int due);
      exp_t e;
      e.nm = nm;
      e.kind = kind;
      e.val = v;
      e.due = due;
      sbq.push_back(e);
   endtask

   task automatic set_bit(int b);
      bus.pos_in = 21'h1 << b;
   endtask

   initial begin
      int r;
      rst = 1'b0;
      bus.pos_in = 21'h1;
      tick(3);
      push("rst_an", 0, 8'hFF, cyc);
      push("rst_seg", 1, 8'hFF, cyc);
      push("rst_idx", 2, 8'd0, cyc);
      push("rst_lap", 3, 8'd0, cyc);
      push("rst_err", 4, 8'd0, cyc);
      tick(1);
      rst = 1'b1;
      r = cyc;
      push("idle_idx", 2, 8'd0, r + 2);
      push("idle_err", 4, 8'd0, r + 2);
      push("idle_an", 0, 8'hFF, r + 3);
      for (int j = 0; j < 40; j++) begin
         push("scan_an", 0, an_tbl[(j / 4) % 8], r + 4 + j);
         push("scan_seg", 1, seg_tbl[(j / 4) % 8], r + 4 + j);
      end
      tick(44);

      for (int b = 1; b < 20; b++) begin
         set_bit(b);
         push("walk_idx", 2, 8'(b), cyc + 2);
         push("walk_lap", 3, 8'd0, cyc + 2);
         tick(5);
      end
      set_bit(20);
      push("walk_idx20", 2, 8'd20, cyc + 2);
      push("walk_d0", 10, 8'hC0, cyc + 2);
      push("walk_d1", 11, 8'hA4, cyc + 2);
      tick(45);
      set_bit(0);
      push("lap_pre", 3, 8'd0, cyc + 1);
      push("lap_one", 3, 8'd1, cyc + 2);
      push("lap_idx0", 2, 8'd0, cyc + 2);
      push("lap_d4", 14, 8'hF9, cyc + 2);
      push("lap_d5", 15, 8'hFF, cyc + 2);
      tick(45);

      for (int k = 0; k < 98; k++) begin
         for (int b = 1; b <= 20; b++) begin
            set_bit(b);
            push("rot_idx", 2, 8'(b), cyc + 2);
            tick(1);
         end
         set_bit(0);
         push("rot_lap", 3, 8'(k + 2), cyc + 2);
         tick(1);
      end
      push("d4_99", 14, 8'h90, cyc);
      push("d5_99", 15, 8'h90, cyc);
      tick(45);
      for (int b = 1; b <= 20; b++) begin
         set_bit(b);
         tick(1);
      end
      set_bit(0);
      push("wrap_lap", 3, 8'd0, cyc + 2);
      push("wrap_d4", 14, 8'hC0, cyc + 2);
      push("wrap_d5", 15, 8'hFF, cyc + 2);
      tick(45);

      bus.pos_in = 21'h0;
      push("zero_err", 4, 8'd1, cyc + 2);
      push("zero_idx", 2, 8'd0, cyc + 2);
      push("zero_d0", 10, 8'hBF, cyc + 2);
      push("zero_d1", 11, 8'hBF, cyc + 2);
      tick(45);
      bus.pos_in = 21'h3;
      push("two_err", 4, 8'd1, cyc + 2);
      push("two_idx", 2, 8'd0, cyc + 2);
      tick(5);
      bus.pos_in = 21'h10;
      push("rec_idx", 2, 8'd4, cyc + 2);
      push("rec_err", 4, 8'd0, cyc + 2);
      push("rec_lap", 3, 8'd0, cyc + 2);
      tick(5);

      set_bit(20);
      push("jmp_idx20", 2, 8'd20, cyc + 2);
      tick(5);
      set_bit(5);
      push("jmp_idx5", 2, 8'd5, cyc + 2);
      push("jmp_lap", 3, 8'd0, cyc + 2);
      tick(5);
      set_bit(20);
      tick(5);
      bus.pos_in = 21'h0;
      push("gap_err", 4, 8'd1, cyc + 2);
      tick(3);
      set_bit(0);
      push("gap_idx", 2, 8'd0, cyc + 2);
      push("gap_err0", 4, 8'd0, cyc + 2);
      push("gap_lap", 3, 8'd0, cyc + 2);
      push("gap_lap2", 3, 8'd0, cyc + 4);
      tick(6);

      set_bit(7);
      push("pre_idx7", 2, 8'd7, cyc + 2);
      tick(6);
      rst = 1'b0;
      push("mid_an", 0, 8'hFF, cyc);
      push("mid_seg", 1, 8'hFF, cyc);
      push("mid_idx", 2, 8'd0, cyc);
      push("mid_err", 4, 8'd0, cyc);
      tick(2);
      rst = 1'b1;
      push("rel_an", 0, 8'hFF, cyc + 3);
      push("rel_an0", 0, 8'hFE, cyc + 4);
      push("rel_seg0", 1, 8'hF8, cyc + 4);
      push("rel_an1", 0, 8'hFD, cyc + 8);
      tick(10);

      for (int k = 0; k < 200 && sbq.size() > 0; k++) tick(1);
      while (sbq.size() > 0) begin
         chk({sbq[0].nm, "_pending"}, 8'hXX, sbq[0].val);
         sbq.delete(0);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/led_pos_display.md
Name: led_pos_display

Overview:
- Consumer end of the LED chase timer's 21-bit one-hot position vector.
- Validates and encodes the position to an index (0..20) and counts completed laps (20 -> 0 wraps).
- Drives both numbers onto the board's 8-digit multiplexed seven-segment display by time-division scanning.
- Sits beside the LED driver in the LED display control top level and shares the timer output bus.

Parameters:
- WIDTH, 21: width of the one-hot position input; the index range is 0..WIDTH-1 (WIDTH ≤ 32).
- SCAN_DIV, 100_000: clk cycles per displayed digit (1 kHz per digit at 100 MHz); the minimum legal value is 2.
- LAP_MOD, 100: the lap counter wraps to 0 at LAP_MOD.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- pos_in  input  WIDTH  one-hot position vector from the timer.
- an  output  8  digit enables, active-low, one-cold; an[0] is the rightmost digit.
- seg  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.
- idx_o  output  5  encoded index of the current valid position.
- lap_o  output  7  completed lap count, 0..LAP_MOD-1.
- err_o  output  1  high while the registered input is not exactly one-hot.

Behaviour:
- Reset (rst low, asynchronous):
  - an=8'hFF, seg=8'hFF, idx_o=0, lap_o=0, err_o=0.
  - Scan counter and digit pointer = 0.
  - prev_valid=0.
- Stage 1: pos_in is registered into pos_q every cycle.
- Stage 2 (combinational from pos_q, registered on the next edge):
  - valid=1 iff popcount(pos_q)==1.
  - If valid: idx_o <= bit position, err_o <= 0.
  - If not valid: idx_o holds its last value, err_o <= 1.
  - Latency from a pos_in change to idx_o/err_o is 2 clk edges.
- Step and lap logic:
  - A step occurs when valid, prev_valid, and the new index differs from the held previous index.
  - If a step goes from prev index WIDTH-1 to new index 0, lap_o increments.
  - lap_o wraps LAP_MOD-1 -> 0.
  - Any other jump, including backward jumps, does not change lap_o.
  - The first valid vector after reset or after an invalid period only loads prev (prev_valid <= 1) and never counts a lap.
  - An invalid cycle clears prev_valid.
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 it returns to 0 and the digit pointer advances 0..7, wrapping 7 -> 0.
  - an and seg are registered together. an = ~(1<<ptr), updated on the same edge as seg, so no ghosting cycle exists.
- Digit content:
  - ptr 0: idx ones. ptr 1: idx tens (blank if tens==0).
  - ptr 4: lap ones. ptr 5: lap tens (blank if tens==0).
  - ptr 2, 3, 6, 7: blank (seg=8'hFF).
  - While err_o=1, ptr 0 and 1 show '-' (segment g only, seg=8'hBF).
  - The dp segment is always off.
- Decimal split: tens = value/10 and ones = value%10, computed by compare-subtract. Values are at most 99, so no divider is needed.
- Segment codes (active-low):
  - 0:C0, 1:F9, 2:A4, 3:B0, 4:99
  - 5:92, 6:82, 7:F8, 8:80, 9:90
- Simultaneous events: a lap increment on the same edge as a scan advance has no interaction. The displayed lap value updates on the next refresh of digits 4/5.
- Reset mid-scan: all outputs return to reset values immediately. After release, scanning restarts at ptr 0 after SCAN_DIV cycles.

Test Plan:
- Reset and idle:
  - Stimulus: SCAN_DIV=4, hold rst low, pos_in=21'h1, then release.
  - Required: an=FF and seg=FF during reset. Two edges after release, idx_o=0 and err_o=0. At the first advance, an=8'hFE and seg=C0.
- Walk and lap:
  - Stimulus: rotate pos_in one bit per 5 cycles through bit 20 then bit 0.
  - Required: idx_o follows 0..20 with 2-cycle latency; lap_o becomes 1 only after the 20->0 step. Digits 1/0 show "2","0" at idx 20.
- Lap wrap:
  - Stimulus: force 100 full rotations.
  - Required: lap_o goes 99 -> 0; digits 5/4 show "9","9" then blank,"0".
- Invalid input:
  - Stimulus: pos_in=0, then 21'h3, then 21'h10.
  - Required: err_o=1 and digits 0/1 show BF. idx_o holds its prior value. After 21'h10, idx_o=4 and err_o=0, with no lap counted.
- Non-lap jump:
  - Stimulus: step 20 -> 5, and a valid 0 that follows an invalid vector.
  - Required: lap_o is unchanged in both cases.
- Scan order:
  - Stimulus: observe 40 cycles with SCAN_DIV=4.
  - Required: an sequence FE,FD,FB,F7,EF,DF,BF,7F, each held 4 cycles, then repeats. Blank digits have seg=FF.
